// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// ---------------------------------------------------------------------------
// Decode-side read guard for the architectural register file. It keeps one
// small in-flight write counter per register. A counter rises when an
// instruction that writes the register issues. It falls when writeback
// retires that write. Decode is stalled while a source operand still has a
// write outstanding, or while the destination counter is saturated.
//
// Optional feature (macro SB_BYPASS_EN):
//   Defined   - a source whose last outstanding write retires this cycle does
//               not stall, and rs_bypass/rt_bypass tells decode to take the
//               operand from WriteData.
//   Undefined - such a source stalls for one more cycle, until the register
//               file holds the value. Both bypass outputs are tied to 0.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous active-low reset
//   issue_valid  in   decode presents an instruction this cycle
//   issue_wre    in   presented instruction writes a register
//   issue_dest   in   destination register of the presented instruction
//   rs, rt       in   source registers of the presented instruction
//   rs_used      in   rs is actually read
//   rt_used      in   rt is actually read
//   RegWre       in   writeback retires a register write this cycle
//   WriteReg     in   register being written back
//   stall        out  hold decode; the instruction does not issue
//   rs_bypass    out  take rs from WriteData instead of the register file
//   rt_bypass    out  take rt from WriteData instead of the register file
//   busy_mask    out  bit i set while register i has writes in flight
//   err          out  sticky flag: retire seen for a register with no writes
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            issue_valid,
  input  logic            issue_wre,
  input  logic [4:0]      issue_dest,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic            rs_used,
  input  logic            rt_used,
  input  logic            RegWre,
  input  logic [4:0]      WriteReg,
  output logic            stall,
  output logic            rs_bypass,
  output logic            rt_bypass,
  output logic [NREG-1:0] busy_mask,
  output logic            err
);

`ifdef SB_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic [CNT_W-1:0] cnt_rs, cnt_rt, cnt_dst, cnt_wr;
  logic             retire, underflow;
  logic             rs_pend, rt_pend, rs_hit, rt_hit;
  logic             rs_block, rt_block, dest_full;
  logic             issue_fire;
  logic             inc_r, dec_r;

  assign cnt_rs  = cnt_q[rs];
  assign cnt_rt  = cnt_q[rt];
  assign cnt_dst = cnt_q[issue_dest];
  assign cnt_wr  = cnt_q[WriteReg];

  // Register 0 is hardwired in the register file, so its writes are ignored.
  assign retire    = RegWre & (WriteReg != 5'd0);
  assign underflow = retire & (cnt_wr == CNT_ZERO);

  assign rs_pend = rs_used & (rs != 5'd0) & (cnt_rs != CNT_ZERO);
  assign rt_pend = rt_used & (rt != 5'd0) & (cnt_rt != CNT_ZERO);

  // The last outstanding write to the source is being retired right now.
  assign rs_hit = retire & (WriteReg == rs) & (cnt_rs == CNT_ONE);
  assign rt_hit = retire & (WriteReg == rt) & (cnt_rt == CNT_ONE);

  assign rs_block = rs_pend & ~(BYPASS_EN & rs_hit);
  assign rt_block = rt_pend & ~(BYPASS_EN & rt_hit);

  // A saturated counter may still accept an issue if a retire frees a slot
  // in the same cycle; the net count is then unchanged.
  assign dest_full = issue_wre & (issue_dest != 5'd0) & (cnt_dst == CNT_MAX) &
                     ~(retire & (WriteReg == issue_dest));

  assign stall = issue_valid & (rs_block | rt_block | dest_full);

  assign rs_bypass = BYPASS_EN & issue_valid & ~stall & rs_pend & rs_hit;
  assign rt_bypass = BYPASS_EN & issue_valid & ~stall & rt_pend & rt_hit;

  assign issue_fire = issue_valid & ~stall & issue_wre & (issue_dest != 5'd0);

  always_comb begin
    cnt_d = cnt_q;
    inc_r = 1'b0;
    dec_r = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc_r = issue_fire & (issue_dest == 5'(r));
      dec_r = retire & (WriteReg == 5'(r)) & (cnt_q[r] != CNT_ZERO);
      case ({inc_r, dec_r})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
    cnt_d[0] = CNT_ZERO;
  end

  assign err_d = err_q | underflow;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_mask[r] = (cnt_q[r] != CNT_ZERO);
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. Expected values are hand-derived from
// the scoreboard rules; bypass-dependent expectations follow SB_BYPASS_EN.
module tb_reg_scoreboard;

  logic        Clk;
  logic        Reset;
  logic        issue_valid;
  logic        issue_wre;
  logic [4:0]  issue_dest;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_used;
  logic        rt_used;
  logic        RegWre;
  logic [4:0]  WriteReg;
  logic        stall;
  logic        rs_bypass;
  logic        rt_bypass;
  logic [31:0] busy_mask;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .issue_valid(issue_valid),
    .issue_wre  (issue_wre),
    .issue_dest (issue_dest),
    .rs         (rs),
    .rt         (rt),
    .rs_used    (rs_used),
    .rt_used    (rt_used),
    .RegWre     (RegWre),
    .WriteReg   (WriteReg),
    .stall      (stall),
    .rs_bypass  (rs_bypass),
    .rt_bypass  (rt_bypass),
    .busy_mask  (busy_mask),
    .err        (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    issue_valid = 1'b0;
    issue_wre   = 1'b0;
    issue_dest  = 5'd0;
    rs          = 5'd0;
    rt          = 5'd0;
    rs_used     = 1'b0;
    rt_used     = 1'b0;
    RegWre      = 1'b0;
    WriteReg    = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    Reset = 1'b0;
    idle();
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_byp", {30'd0, rs_bypass, rt_bypass}, 32'd0);
    tick();
    Reset = 1'b1;
    tick();

    // Write to r5 issues, then a read of r5 must stall
    issue_valid = 1'b1; issue_wre = 1'b1; issue_dest = 5'd5;
    #1 chk("w5_issue_stall", 32'(stall), 32'd0);
    tick();
    issue_wre = 1'b0; issue_dest = 5'd0; rs = 5'd5; rs_used = 1'b1;
    #1;
    chk("raw5_stall", 32'(stall), 32'd1);
    chk("raw5_busy", busy_mask, 32'h0000_0020);
    chk("raw5_nobyp", 32'(rs_bypass), 32'd0);

    // Same-cycle retire of the only outstanding write to r5
    RegWre = 1'b1; WriteReg = 5'd5;
    #1;
    chk("wb5_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
    chk("wb5_rs_byp", 32'(rs_bypass), BYP ? 32'd1 : 32'd0);
    chk("wb5_rt_byp", 32'(rt_bypass), 32'd0);
    tick();
    RegWre = 1'b0; WriteReg = 5'd0;
    #1;
    chk("after5_stall", 32'(stall), 32'd0);
    chk("after5_busy", busy_mask, 32'h0);
    chk("after5_byp", 32'(rs_bypass), 32'd0);

    // Fill r7 to saturation (3 outstanding)
    idle();
    issue_valid = 1'b1; issue_wre = 1'b1; issue_dest = 5'd7;
    #1 chk("w7_1", 32'(stall), 32'd0);
    tick();
    chk("w7_2", 32'(stall), 32'd0);
    tick();
    chk("w7_3", 32'(stall), 32'd0);
    tick();
    chk("w7_busy", busy_mask, 32'h0000_0080);
    chk("w7_full", 32'(stall), 32'd1);
    RegWre = 1'b1; WriteReg = 5'd7;
    #1 chk("w7_full_retire", 32'(stall), 32'd0);
    tick();
    // Count must still be 3: a new issue to r7 is refused again
    RegWre = 1'b0; WriteReg = 5'd0;
    #1 chk("w7_still_full", 32'(stall), 32'd1);

    // Stalled instruction (reads r7, writes r8) leaves no trace
    issue_dest = 5'd8; rt = 5'd7; rt_used = 1'b1;
    #1 chk("rt7_stall", 32'(stall), 32'd1);
    tick();
    chk("stalled_no_effect", busy_mask, 32'h0000_0080);
    rt_used = 1'b0;
    #1 chk("rt_unused_nostall", 32'(stall), 32'd0);

    // Drain r7: two retires, then the last one coincides with an rt read
    idle();
    RegWre = 1'b1; WriteReg = 5'd7;
    tick();
    tick();
    chk("r7_one_left", busy_mask, 32'h0000_0080);
    issue_valid = 1'b1; rt = 5'd7; rt_used = 1'b1;
    #1;
    chk("wb7_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
    chk("wb7_rt_byp", 32'(rt_bypass), BYP ? 32'd1 : 32'd0);
    chk("wb7_rs_byp", 32'(rs_bypass), 32'd0);
    tick();
    idle();
    #1;
    chk("r7_drained", busy_mask, 32'h0);
    chk("r7_err", 32'(err), 32'd0);

    // Register 0 is never tracked
    issue_valid = 1'b1; issue_wre = 1'b1; issue_dest = 5'd0;
    rs = 5'd0; rt = 5'd0; rs_used = 1'b1; rt_used = 1'b1;
    #1 chk("r0_stall", 32'(stall), 32'd0);
    tick();
    chk("r0_stall2", 32'(stall), 32'd0);
    chk("r0_busy", busy_mask, 32'h0);
    idle();
    RegWre = 1'b1; WriteReg = 5'd0;
    tick();
    chk("r0_retire_err", 32'(err), 32'd0);

    // Retire with nothing outstanding: sticky error, no underflow
    WriteReg = 5'd9;
    tick();
    chk("uf_err", 32'(err), 32'd1);
    chk("uf_busy", busy_mask, 32'h0);
    idle();
    issue_valid = 1'b1; rs = 5'd9; rs_used = 1'b1;
    #1 chk("uf_r9_nostall", 32'(stall), 32'd0);
    tick();
    chk("uf_err_sticky", 32'(err), 32'd1);

    // cnt[3]=2, cnt[4]=1, then asynchronous reset mid-cycle
    idle();
    issue_valid = 1'b1; issue_wre = 1'b1; issue_dest = 5'd3;
    tick();
    tick();
    issue_dest = 5'd4;
    tick();
    idle();
    issue_valid = 1'b1; rs = 5'd3; rs_used = 1'b1;
    #1;
    chk("pre_rst_busy", busy_mask, 32'h0000_0018);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    chk("pre_rst_err", 32'(err), 32'd1);
    Reset = 1'b0;
    #1;
    chk("arst_busy", busy_mask, 32'h0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    tick();
    Reset = 1'b1;
    idle();
    tick();
    chk("post_rst_busy", busy_mask, 32'h0);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Decode-side read guard for the 32x32 register file.
- Tracks in-flight writes to each architectural register. Each register has a count that rises when a writing instruction issues and falls when the writeback stage retires the write (RegWre).
- Stalls decode while a source operand is pending.
- Optionally flags a same-cycle writeback bypass so decode can take WriteData directly.
- Sits between the decode/issue logic and the register file write port.

Parameters:
- CNT_W, 2, width of each per-register in-flight counter. Max outstanding writes per register is 2^CNT_W-1.
- NREG, 32, number of architectural registers. Register 0 is never tracked.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- issue_valid  input  1  decode presents an instruction this cycle.
- issue_wre  input  1  presented instruction writes a register.
- issue_dest  input  5  destination register of presented instruction.
- rs  input  5  source register 1 of presented instruction.
- rt  input  5  source register 2 of presented instruction.
- rs_used  input  1  rs is actually read.
- rt_used  input  1  rt is actually read.
- RegWre  input  1  writeback retires a register write this cycle.
- WriteReg  input  5  register being written back.
- stall  output  1  hold decode. The instruction is not issued this cycle.
- rs_bypass  output  1  take rs operand from WriteData, not the register file.
- rt_bypass  output  1  take rt operand from WriteData, not the register file.
- busy_mask  output  32  bit i = 1 when cnt[i] != 0. Bit 0 is always 0.
- err  output  1  sticky protocol-error flag.

Behaviour:
- State: cnt[1..31], each CNT_W bits, plus err. All are cleared asynchronously when Reset=0. While in reset, stall=0, bypass outputs=0, busy_mask=0, err=0.
- retire = RegWre & (WriteReg != 0).
- Source pending (rs shown; rt identical):
  - rs_pend = rs_used & (rs != 0) & (cnt[rs] != 0).
  - rs_hit = retire & (WriteReg == rs) & (cnt[rs] == 1).
  - rs_block = rs_pend & ~(bypass enabled & rs_hit).
- Destination saturation: dest_full = issue_wre & (issue_dest != 0) & (cnt[issue_dest] == all-ones) & ~(retire & WriteReg == issue_dest).
- stall = issue_valid & (rs_block | rt_block | dest_full). It is combinational with zero latency.
- rs_bypass = issue_valid & ~stall & rs_pend & rs_hit. rt_bypass is analogous. Both are 0 when the optional feature is off.
- issue_fire = issue_valid & ~stall & issue_wre & (issue_dest != 0).
- Counter update at the rising edge of Clk, per register r:
  - +1 if issue_fire targets r.
  - -1 if retire targets r and cnt[r] != 0.
  - Both in the same cycle: count unchanged.
- Retire to a register with cnt == 0: the counter stays 0 (no underflow) and err is set.
- err clears only on reset.
- Writes to register 0 are never counted and never cause a stall. This matches the register file, which discards writes to register 0.
- A stalled instruction has no effect on state. Decode re-presents it on the next cycle.
- Reset asserted mid-operation drops all pending counts. The pipeline is flushed by the same reset.

Optional Feature:
- Macro: SB_BYPASS_EN.
- Defined: a source whose last outstanding write retires in the current cycle does not stall, and the matching rs_bypass/rt_bypass is asserted.
- Undefined:
  - The source stalls until the cycle after the retire, when the register file holds the value.
  - rs_bypass and rt_bypass are tied to 0.
  - Costs one extra stall cycle per read-after-write (RAW) dependency that resolves exactly at writeback.

Test Plan:
- Reset, then issue a write to dest=5. Next cycle, present rs=5, rs_used=1 with no retire. Expect stall=1, busy_mask=0x00000020.
- cnt[5]=1, and in the same cycle present rs=5 with RegWre=1, WriteReg=5:
  - With SB_BYPASS_EN: stall=0, rs_bypass=1.
  - Without it: stall=1 that cycle, then stall=0 and busy_mask=0 the next cycle.
- Issue three writes to dest=7 (cnt=3, CNT_W=2). A fourth issue to dest=7 gives stall=1. Adding RegWre/WriteReg=7 in that same cycle gives stall=0, and cnt stays 3.
- Issue with dest=0, then present rs=0 and rt=0. Expect no stall, busy_mask bit 0 = 0, and a retire with WriteReg=0 leaves err=0.
- RegWre=1, WriteReg=9 with cnt[9]=0. Expect err=1 on the next edge, cnt[9] stays 0, and err persists until Reset=0.
- With cnt[3]=2 and cnt[4]=1, assert Reset=0 asynchronously between edges. Expect busy_mask=0 and stall=0 immediately.
